uart_rx_byte_assembler: RTL and testbench

- Sits directly downstream of the RX bit detector. Consumes its per-bit strobes and end-of-frame status.
- Assembles 8 data bits (LSB first) into a byte and validates the frame.
- Buffers good bytes in a small FIFO with a valid/ready host interface.
- Reports sticky framing and overrun errors to the host.

---
 rtl/uart_rx_byte_assembler.sv | 170 +++++++++++++++++
 tb/tb_uart_rx_byte_assembler.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte_assembler.sv
// UART RX byte assembler: collects 8 LSB-first data bits from the bit detector,
// validates the frame on the stop strobe and buffers good bytes in a small FIFO
// with a valid/ready host port and sticky framing/overrun flags.
module uart_rx_byte_assembler #(
  parameter int unsigned  DEPTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          active_rx,
  input  logic          bit_ready,
  input  logic          rx_bit,
  input  logic          framing_err,
  input  logic          done,
  output logic [7:0]    data_out,
  output logic          data_out_valid,
  input  logic          data_out_ready,
  output logic [CW-1:0] fifo_count,
  output logic          framing_err_flag,
  output logic          overrun_flag,
  input  logic          err_clear
);

  localparam int unsigned PW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_STOP    = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [7:0]    sr_q, sr_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          bad_q, bad_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  logic          fe_q, fe_d;
  logic          ov_q, ov_d;

  logic          commit_c;
  logic          frame_err_c;
  logic          pop_c;
  logic          full_c;
  logic          push_c;
  logic          overrun_c;

  // Frame FSM: shift data bits, then judge the frame when the stop strobe arrives.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    bad_d       = bad_q;
    commit_c    = 1'b0;
    frame_err_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (active_rx) begin
          state_d = S_COLLECT;
          cnt_d   = 4'd0;
          bad_d   = 1'b0;
          // A bit arriving on the same cycle as active_rx rises belongs to this frame.
          if (bit_ready) begin
            sr_d  = {rx_bit, sr_q[7:1]};
            cnt_d = 4'd1;
          end
        end
      end
      S_COLLECT: begin
        if (done || !active_rx) begin
          // Short frame or aborted frame: drop the partial byte.
          frame_err_c = 1'b1;
          state_d     = S_IDLE;
        end else if (bit_ready) begin
          sr_d  = {rx_bit, sr_q[7:1]};
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (done) begin
          if (framing_err || bad_q || bit_ready) begin
            frame_err_c = 1'b1;
          end else begin
            commit_c = 1'b1;
          end
          state_d = S_IDLE;
        end else if (!active_rx) begin
          frame_err_c = 1'b1;
          state_d     = S_IDLE;
        end else if (bit_ready) begin
          // A ninth data bit means the detector lost framing.
          bad_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO bookkeeping: a commit into a full FIFO only lands if the head leaves the same cycle.
  always_comb begin
    pop_c     = valid_q && data_out_ready;
    full_c    = (count_q == CW'(DEPTH));
    push_c    = commit_c && (!full_c || pop_c);
    overrun_c = commit_c && full_c && !pop_c;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (push_c) begin
      mem_d[wr_ptr_q] = sr_q;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(push_c) - CW'(pop_c);
    valid_d = (count_d != '0);
  end

  // Sticky error flags: a new event in the same cycle as err_clear leaves the flag set.
  always_comb begin
    fe_d = (fe_q & ~err_clear) | frame_err_c;
    ov_d = (ov_q & ~err_clear) | overrun_c;
  end

  // Control and status registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sr_q     <= '0;
      cnt_q    <= '0;
      bad_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      fe_q     <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      bad_q    <= bad_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      fe_q     <= fe_d;
      ov_q     <= ov_d;
    end
  end

  // FIFO storage; contents are meaningless while empty so no reset is needed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign data_out         = mem_q[rd_ptr_q];
  assign data_out_valid   = valid_q;
  assign fifo_count       = count_q;
  assign framing_err_flag = fe_q;
  assign overrun_flag     = ov_q;

endmodule

// File: tb/tb_uart_rx_byte_assembler.sv
// Randomized bench for uart_rx_byte_assembler against a queue-based frame model.
module tb_uart_rx_byte_assembler;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic          active_rx;
  logic          bit_ready;
  logic          rx_bit;
  logic          framing_err;
  logic          done;
  logic [7:0]    data_out;
  logic          data_out_valid;
  logic          data_out_ready;
  logic [CW-1:0] fifo_count;
  logic          framing_err_flag;
  logic          overrun_flag;
  logic          err_clear;

  int checks;
  int errors;

  // Reference model: buffered bytes in arrival order plus the two sticky flags.
  logic [7:0] exp_q [$];
  logic       exp_fe;
  logic       exp_ov;

  uart_rx_byte_assembler #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .active_rx        (active_rx),
    .bit_ready        (bit_ready),
    .rx_bit           (rx_bit),
    .framing_err      (framing_err),
    .done             (done),
    .data_out         (data_out),
    .data_out_valid   (data_out_valid),
    .data_out_ready   (data_out_ready),
    .fifo_count       (fifo_count),
    .framing_err_flag (framing_err_flag),
    .overrun_flag     (overrun_flag),
    .err_clear        (err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    active_rx = 1'b0;
    repeat (n) tick();
  endtask

  // Drive the data phase of a frame: nbits data bits, then 'extra' surplus bits.
  task automatic frame_bits(input logic [7:0] b, input int nbits, input int extra);
    active_rx = 1'b1;
    if (nbits == 0 || $urandom_range(0, 1) == 0) tick();
    for (int i = 0; i < nbits; i++) begin
      bit_ready = 1'b1;
      rx_bit    = b[i];
      tick();
      bit_ready = 1'b0;
      rx_bit    = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    for (int i = 0; i < extra; i++) begin
      bit_ready = 1'b1;
      rx_bit    = 1'($urandom_range(0, 1));
      tick();
      bit_ready = 1'b0;
      tick();
    end
  endtask

  // Stop strobe; the model applies pop, clear, then the frame outcome.
  task automatic finish_frame(input logic fe, input logic pop, input logic clr,
                              input logic whole, input logic [7:0] b);
    done           = 1'b1;
    framing_err    = fe;
    active_rx      = 1'b0;
    data_out_ready = pop;
    err_clear      = clr;
    tick();
    done           = 1'b0;
    framing_err    = 1'b0;
    data_out_ready = 1'b0;
    err_clear      = 1'b0;
    if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
    if (clr) begin
      exp_fe = 1'b0;
      exp_ov = 1'b0;
    end
    if (whole && !fe) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else exp_ov = 1'b1;
    end else begin
      exp_fe = 1'b1;
    end
  endtask

  task automatic abort_frame();
    active_rx = 1'b0;
    tick();
    exp_fe = 1'b1;
  endtask

  task automatic clear_flags();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    exp_fe = 1'b0;
    exp_ov = 1'b0;
  endtask

  task automatic good_frame(input logic [7:0] b);
    frame_bits(b, 8, 0);
    finish_frame(1'b0, 1'b0, 1'b0, 1'b1, b);
    idle(1);
  endtask

  task automatic test_drain(input string name);
    for (int k = 0; k < DEPTH + 1 && exp_q.size() > 0; k++) begin
      checks++;
      if (data_out_valid !== 1'b1 || data_out !== exp_q[0]) begin
        errors++;
        $display("FAIL %s drain[%0d]: got valid=%b data=%h expected valid=1 data=%h",
                 name, k, data_out_valid, data_out, exp_q[0]);
      end
      data_out_ready = 1'b1;
      tick();
      data_out_ready = 1'b0;
      void'(exp_q.pop_front());
    end
    checks++;
    if (data_out_valid !== 1'b0 || fifo_count !== '0) begin
      errors++;
      $display("FAIL %s drain_empty: got valid=%b count=%0d expected valid=0 count=0",
               name, data_out_valid, fifo_count);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    exp_q.delete();
    exp_fe = 1'b0;
    exp_ov = 1'b0;
    checks++;
    if (data_out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", data_out_valid);
    end
    checks++;
    if (fifo_count !== '0) begin
      errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count);
    end
    checks++;
    if (framing_err_flag !== 1'b0 || overrun_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got fe=%b ov=%b expected 0 0", framing_err_flag, overrun_flag);
    end
  endtask

  task automatic test_single_byte();
    frame_bits(8'hA5, 8, 0);
    checks++;
    if (data_out_valid !== 1'b0) begin
      errors++; $display("FAIL a5_pre_done_valid: got %b expected 0", data_out_valid);
    end
    finish_frame(1'b0, 1'b0, 1'b0, 1'b1, 8'hA5);
    checks++;
    if (data_out !== 8'hA5 || data_out_valid !== 1'b1 || fifo_count !== CW'(1)) begin
      errors++;
      $display("FAIL a5_commit: got data=%h valid=%b count=%0d expected a5 1 1",
               data_out, data_out_valid, fifo_count);
    end
    checks++;
    if (framing_err_flag !== 1'b0 || overrun_flag !== 1'b0) begin
      errors++;
      $display("FAIL a5_flags: got fe=%b ov=%b expected 0 0", framing_err_flag, overrun_flag);
    end
    // Holding ready low keeps the head stable.
    tick();
    checks++;
    if (data_out !== 8'hA5 || data_out_valid !== 1'b1) begin
      errors++; $display("FAIL a5_hold: got data=%h valid=%b expected a5 1", data_out, data_out_valid);
    end
    test_drain("a5");
  endtask

  task automatic test_framing_err();
    frame_bits(8'h3C, 8, 0);
    finish_frame(1'b1, 1'b0, 1'b0, 1'b1, 8'h3C);
    checks++;
    if (fifo_count !== '0 || framing_err_flag !== 1'b1) begin
      errors++;
      $display("FAIL fe_set: got count=%0d fe=%b expected 0 1", fifo_count, framing_err_flag);
    end
    clear_flags();
    checks++;
    if (framing_err_flag !== 1'b0) begin
      errors++; $display("FAIL fe_clear: got %b expected 0", framing_err_flag);
    end
    // Clear and a new error on the same edge: the error wins.
    frame_bits(8'h3C, 8, 0);
    finish_frame(1'b1, 1'b0, 1'b1, 1'b1, 8'h3C);
    checks++;
    if (framing_err_flag !== 1'b1) begin
      errors++; $display("FAIL fe_set_wins: got %b expected 1", framing_err_flag);
    end
    clear_flags();
    idle(1);
  endtask

  task automatic test_overrun();
    for (int v = 1; v <= 5; v++) good_frame(8'(v));
    checks++;
    if (fifo_count !== CW'(4) || overrun_flag !== 1'b1 || framing_err_flag !== 1'b0) begin
      errors++;
      $display("FAIL overrun: got count=%0d ov=%b fe=%b expected 4 1 0",
               fifo_count, overrun_flag, framing_err_flag);
    end
    test_drain("overrun");
    clear_flags();
  endtask

  task automatic test_full_pop();
    for (int v = 0; v < DEPTH; v++) good_frame(8'($urandom_range(0, 255)));
    frame_bits(8'h77, 8, 0);
    checks++;
    if (data_out !== exp_q[0]) begin
      errors++; $display("FAIL full_pop_head: got %h expected %h", data_out, exp_q[0]);
    end
    finish_frame(1'b0, 1'b1, 1'b0, 1'b1, 8'h77);
    checks++;
    if (fifo_count !== CW'(4) || overrun_flag !== 1'b0) begin
      errors++;
      $display("FAIL full_pop: got count=%0d ov=%b expected 4 0", fifo_count, overrun_flag);
    end
    test_drain("full_pop");
  endtask

  task automatic test_short_frame();
    frame_bits(8'h5A, 3, 0);
    finish_frame(1'b0, 1'b0, 1'b0, 1'b0, 8'h5A);
    checks++;
    if (fifo_count !== '0 || framing_err_flag !== 1'b1) begin
      errors++;
      $display("FAIL short: got count=%0d fe=%b expected 0 1", fifo_count, framing_err_flag);
    end
    clear_flags();
    good_frame(8'h5A);
    checks++;
    if (data_out !== 8'h5A || fifo_count !== CW'(1)) begin
      errors++;
      $display("FAIL short_next: got data=%h count=%0d expected 5a 1", data_out, fifo_count);
    end
    test_drain("short");
  endtask

  task automatic test_abort();
    frame_bits(8'hC3, 5, 0);
    abort_frame();
    checks++;
    if (fifo_count !== '0 || framing_err_flag !== 1'b1) begin
      errors++;
      $display("FAIL abort_collect: got count=%0d fe=%b expected 0 1", fifo_count, framing_err_flag);
    end
    clear_flags();
    frame_bits(8'hC3, 8, 0);
    abort_frame();
    checks++;
    if (fifo_count !== '0 || framing_err_flag !== 1'b1) begin
      errors++;
      $display("FAIL abort_stop: got count=%0d fe=%b expected 0 1", fifo_count, framing_err_flag);
    end
    clear_flags();
    frame_bits(8'hC3, 8, 1);
    finish_frame(1'b0, 1'b0, 1'b0, 1'b0, 8'hC3);
    checks++;
    if (fifo_count !== '0 || framing_err_flag !== 1'b1) begin
      errors++;
      $display("FAIL extra_bit: got count=%0d fe=%b expected 0 1", fifo_count, framing_err_flag);
    end
    clear_flags();
    idle(1);
  endtask

  task automatic test_reset_mid_frame();
    good_frame(8'h11);
    good_frame(8'h22);
    frame_bits(8'h0F, 4, 0);
    rst_n     = 1'b0;
    active_rx = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    exp_fe = 1'b0;
    exp_ov = 1'b0;
    checks++;
    if (data_out_valid !== 1'b0 || fifo_count !== '0 ||
        framing_err_flag !== 1'b0 || overrun_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got valid=%b count=%0d fe=%b ov=%b expected all 0",
               data_out_valid, fifo_count, framing_err_flag, overrun_flag);
    end
    idle(1);
    good_frame(8'hFF);
    checks++;
    if (data_out !== 8'hFF || fifo_count !== CW'(1) || framing_err_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_next: got data=%h count=%0d fe=%b expected ff 1 0",
               data_out, fifo_count, framing_err_flag);
    end
    test_drain("reset_mid");
  endtask

  task automatic test_random();
    for (int it = 0; it < 60; it++) begin
      int         kind;
      int         nb;
      logic [7:0] b;
      logic       pop;
      logic       clr;
      for (int p = $urandom_range(0, 2); p > 0; p--) begin
        if (exp_q.size() > 0) begin
          checks++;
          if (data_out !== exp_q[0]) begin
            errors++; $display("FAIL rand_pop[%0d]: got %h expected %h", it, data_out, exp_q[0]);
          end
        end
        data_out_ready = 1'b1;
        tick();
        data_out_ready = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      kind = $urandom_range(0, 5);
      b    = 8'($urandom_range(0, 255));
      pop  = 1'($urandom_range(0, 1));
      clr  = ($urandom_range(0, 3) == 0);
      if (kind == 3) begin
        frame_bits(b, $urandom_range(1, 8), 0);
        abort_frame();
      end else begin
        nb = (kind == 4) ? $urandom_range(1, 7) : 8;
        frame_bits(b, nb, (kind == 5) ? 1 : 0);
        if (pop && exp_q.size() > 0) begin
          checks++;
          if (data_out !== exp_q[0]) begin
            errors++; $display("FAIL rand_done_pop[%0d]: got %h expected %h", it, data_out, exp_q[0]);
          end
        end
        finish_frame((kind == 2), pop, clr, (kind < 3), b);
      end
      checks++;
      if (fifo_count !== CW'(exp_q.size()) || data_out_valid !== (exp_q.size() > 0) ||
          framing_err_flag !== exp_fe || overrun_flag !== exp_ov) begin
        errors++;
        $display("FAIL rand_state[%0d]: got count=%0d valid=%b fe=%b ov=%b expected %0d %b %b %b",
                 it, fifo_count, data_out_valid, framing_err_flag, overrun_flag,
                 exp_q.size(), (exp_q.size() > 0), exp_fe, exp_ov);
      end
      if (exp_q.size() > 0) begin
        checks++;
        if (data_out !== exp_q[0]) begin
          errors++; $display("FAIL rand_head[%0d]: got %h expected %h", it, data_out, exp_q[0]);
        end
      end
      idle($urandom_range(1, 3));
    end
    test_drain("random");
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    active_rx      = 1'b0;
    bit_ready      = 1'b0;
    rx_bit         = 1'b0;
    framing_err    = 1'b0;
    done           = 1'b0;
    data_out_ready = 1'b0;
    err_clear      = 1'b0;
    exp_fe         = 1'b0;
    exp_ov         = 1'b0;
    test_reset();
    test_single_byte();
    test_framing_err();
    test_overrun();
    test_full_pop();
    test_short_frame();
    test_abort();
    test_reset_mid_frame();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
